// File: rtl/src_addr_gen.sv
// Multi-channel source-address generator: per-channel load/stride/limit plus a single-channel burst stepper.
// Define SRC_ADDR_GEN_SAT_EN to saturate at the limit instead of wrapping modulo limit+1.
module src_addr_gen #(
    parameter int N   = 10,
    parameter int NCH = 4,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int LW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CW-1:0]      ch_sel,
    input  logic [N-1:0]       D,
    input  logic [N-1:0]       mov_in,
    input  logic               pim_load,
    input  logic               mov_load,
    input  logic               update,
    input  logic               cfg_we,
    input  logic [N-1:0]       cfg_stride,
    input  logic [N-1:0]       cfg_limit,
    input  logic               burst_start,
    input  logic [LW-1:0]      burst_len,
    output logic [NCH*N-1:0]   Q,
    output logic [N-1:0]       q_sel,
    output logic [NCH-1:0]     wrap,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    // state   | meaning
    // ST_IDLE | waiting for burst_start
    // ST_RUN  | stepping bch_q once per cycle, cnt_q steps left
    // ST_FIN  | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bch_q, bch_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    addr_q   [NCH];
    logic [N-1:0]    addr_d   [NCH];
    logic [N-1:0]    stride_q [NCH];
    logic [N-1:0]    stride_d [NCH];
    logic [N-1:0]    limit_q  [NCH];
    logic [N-1:0]    limit_d  [NCH];
    logic [NCH-1:0]  wrap_q, wrap_d;
    logic            cfg_err_q, cfg_err_d;

    logic            burst_stall;
    logic            burst_step;
    logic [N:0]      cfg_lim_p1;
    logic            cfg_bad;
    logic [N:0]      sum;
    logic            sel;
    logic            step;

    assign cfg_lim_p1 = {1'b0, cfg_limit} + (N+1)'(1);
    assign cfg_bad    = (cfg_stride == '0) || ({1'b0, cfg_stride} > cfg_lim_p1);

    always_comb begin
        state_d     = state_q;
        bch_d       = bch_q;
        cnt_d       = cnt_q;
        burst_step  = 1'b0;
        burst_stall = (pim_load || mov_load) && (ch_sel == bch_q);
        case (state_q)
            ST_IDLE: begin
                if (burst_start) begin
                    if (burst_len != '0) begin
                        bch_d   = ch_sel;
                        cnt_d   = burst_len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                // a load to the burst channel freezes the burst for that cycle
                if (!burst_stall) begin
                    burst_step = 1'b1;
                    cnt_d      = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_err_d = cfg_err_q;
        wrap_d    = '0;
        sum       = '0;
        sel       = 1'b0;
        step      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            addr_d[i]   = addr_q[i];
            stride_d[i] = stride_q[i];
            limit_d[i]  = limit_q[i];
        end
        for (int i = 0; i < NCH; i++) begin
            sel  = (ch_sel == CW'(i));
            step = (update && sel && !((state_q == ST_RUN) && (bch_q == CW'(i))))
                 || (burst_step && (bch_q == CW'(i)));
            sum  = {1'b0, addr_q[i]} + {1'b0, stride_q[i]};
            if (pim_load && sel) begin
                addr_d[i] = D;
            end else if (mov_load && sel) begin
                addr_d[i] = mov_in;
            end else if (step) begin
                if (sum > {1'b0, limit_q[i]}) begin
`ifdef SRC_ADDR_GEN_SAT_EN
                    addr_d[i] = limit_q[i];
                    wrap_d[i] = (addr_q[i] < limit_q[i]);
`else
                    addr_d[i] = N'(sum - ({1'b0, limit_q[i]} + (N+1)'(1)));
                    wrap_d[i] = 1'b1;
`endif
                end else begin
                    addr_d[i] = sum[N-1:0];
                end
            end
            if (cfg_we && sel) begin
                limit_d[i] = cfg_limit;
                if (cfg_bad) begin
                    stride_d[i] = N'(1);
                    cfg_err_d   = 1'b1;
                end else begin
                    stride_d[i] = cfg_stride;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bch_q     <= '0;
            cnt_q     <= '0;
            wrap_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i]   <= '0;
                stride_q[i] <= N'(1);
                limit_q[i]  <= '1;
            end
        end else begin
            state_q   <= state_d;
            bch_q     <= bch_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i]   <= addr_d[i];
                stride_q[i] <= stride_d[i];
                limit_q[i]  <= limit_d[i];
            end
        end
    end

    always_comb begin
        Q     = '0;
        q_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            Q[i*N +: N] = addr_q[i];
            if (ch_sel == CW'(i)) begin
                q_sel = addr_q[i];
            end
        end
    end

    assign wrap    = wrap_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_FIN);
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_src_addr_gen.sv
// Scoreboard bench for src_addr_gen: driver feeds a behavioural model that queues expected
// post-edge state; a monitor pops one entry per clock and compares against the DUT.
module tb_src_addr_gen;
    localparam int N   = 10;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int LW  = 8;
    localparam int AMAX = (1 << N) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CW-1:0]     ch_sel;
    logic [N-1:0]      D, mov_in, cfg_stride, cfg_limit;
    logic              pim_load, mov_load, update, cfg_we, burst_start;
    logic [LW-1:0]     burst_len;
    logic [NCH*N-1:0]  Q;
    logic [N-1:0]      q_sel;
    logic [NCH-1:0]    wrap;
    logic              busy, done, cfg_err;

    always #5 clk = ~clk;

    src_addr_gen #(.N(N), .NCH(NCH), .CW(CW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel), .D(D), .mov_in(mov_in),
        .pim_load(pim_load), .mov_load(mov_load), .update(update), .cfg_we(cfg_we),
        .cfg_stride(cfg_stride), .cfg_limit(cfg_limit), .burst_start(burst_start),
        .burst_len(burst_len), .Q(Q), .q_sel(q_sel), .wrap(wrap), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [NCH-1:0][N-1:0] q;
        logic [NCH-1:0]        wrap;
        logic                  busy;
        logic                  done;
        logic                  err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    bit started = 0;

    // reference model: plain integers, burst tracked as "steps left"
    int mq[NCH], ms[NCH], ml[NCH];
    bit merr, m_active, m_fin;
    int m_ch, m_left;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic model_cycle();
        exp_t e;
        bit st[NCH];
        bit [NCH-1:0] w;
        int c, s;
        c = int'(ch_sel);
        w = '0;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                mq[i] = 0; ms[i] = 1; ml[i] = AMAX;
            end
            merr = 0; m_active = 0; m_fin = 0; m_ch = 0; m_left = 0;
        end else begin
            for (int i = 0; i < NCH; i++) st[i] = 0;
            if (update && !(m_active && c == m_ch)) st[c] = 1;
            if (m_active) begin
                if (!((pim_load || mov_load) && c == m_ch)) begin
                    st[m_ch] = 1;
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 0;
                        m_fin = 1;
                    end
                end
            end else if (m_fin) begin
                m_fin = 0;
            end else if (burst_start) begin
                if (burst_len > 0) begin
                    m_active = 1; m_ch = c; m_left = int'(burst_len);
                end else begin
                    m_fin = 1;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (pim_load && c == i) mq[i] = int'(D);
                else if (mov_load && c == i) mq[i] = int'(mov_in);
                else if (st[i]) begin
                    s = mq[i] + ms[i];
                    if (s > ml[i]) begin
`ifdef SRC_ADDR_GEN_SAT_EN
                        w[i] = (mq[i] < ml[i]);
                        mq[i] = ml[i];
`else
                        mq[i] = s - (ml[i] + 1);
                        w[i] = 1;
`endif
                    end else begin
                        mq[i] = s;
                    end
                end
            end
            if (cfg_we) begin
                ml[c] = int'(cfg_limit);
                if (cfg_stride == 0 || int'(cfg_stride) > int'(cfg_limit) + 1) begin
                    ms[c] = 1;
                    merr = 1;
                end else begin
                    ms[c] = int'(cfg_stride);
                end
            end
        end
        for (int i = 0; i < NCH; i++) e.q[i] = N'(mq[i]);
        e.wrap = w;
        e.busy = m_active;
        e.done = m_fin;
        e.err  = merr;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        rst_n = 1'b1; ch_sel = '0; D = '0; mov_in = '0;
        pim_load = 0; mov_load = 0; update = 0; cfg_we = 0;
        cfg_stride = '0; cfg_limit = '0; burst_start = 0; burst_len = '0;
    endtask

    // call at a negedge with inputs set; returns at the next negedge
    task automatic tick();
        #1;
        if (started && rst_n) chk("q_sel", int'(q_sel), mq[int'(ch_sel)]);
        model_cycle();
        if (!rst_n) started = 1;
        @(negedge clk);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < NCH; i++)
                chk($sformatf("q%0d", i), int'(Q[i*N +: N]), int'(e.q[i]));
            chk("wrap", int'(wrap), int'(e.wrap));
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("cfg_err", int'(cfg_err), int'(e.err));
        end
    end

    initial begin
        int nb, nd;
        int exp3[6];
        exp3 = '{1021, 1022, 1023, 0, 1, 2};
        idle_in();
        @(negedge clk);

        // reset and wrap on ch1
        rst_n = 0; tick(); tick();
        idle_in();
        chk("rst_q", int'(Q), 0);
        chk("rst_busy", int'(busy), 0);
        ch_sel = 1; cfg_we = 1; cfg_stride = 3; cfg_limit = 10; tick();
        idle_in(); ch_sel = 1; pim_load = 1; D = 8; tick();
        idle_in(); ch_sel = 1; update = 1; tick();
        chk("tp1_q1", int'(Q[1*N +: N]), 0);
        chk("tp1_wrap", int'(wrap), 4'b0010);
        idle_in(); tick();
        chk("tp1_wrap_clr", int'(wrap), 0);

        // load priority on ch0
        ch_sel = 0; pim_load = 1; D = 5; mov_load = 1; mov_in = 9; tick();
        chk("tp2_pim_wins", int'(Q[0 +: N]), 5);
        idle_in(); ch_sel = 0; mov_load = 1; mov_in = 9; update = 1; tick();
        chk("tp2_mov_wins", int'(Q[0 +: N]), 9);

        // burst ch2 across the top of the address space
        idle_in(); ch_sel = 2; cfg_we = 1; cfg_stride = 1; cfg_limit = 1023; tick();
        idle_in(); ch_sel = 2; pim_load = 1; D = 1020; tick();
        idle_in(); ch_sel = 2; burst_start = 1; burst_len = 6; tick();
        nb = busy; nd = 0;
        idle_in();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("tp3_q2_%0d", k), int'(Q[2*N +: N]), exp3[k]);
            chk($sformatf("tp3_wrap_%0d", k), int'(wrap[2]), (k == 3) ? 1 : 0);
            nb += busy; nd += done;
        end
        chk("tp3_done_last", int'(done), 1);
        tick(); nb += busy; nd += done;
        chk("tp3_busy_cycles", nb, 6);
        chk("tp3_done_cycles", nd, 1);

        // burst ch3 with a stalling load
        ch_sel = 3; burst_start = 1; burst_len = 4; tick();
        nb = busy;
        idle_in(); tick(); nb += busy;
        ch_sel = 3; pim_load = 1; D = 100; tick(); nb += busy;
        idle_in();
        for (int k = 0; k < 4; k++) begin tick(); nb += busy; end
        chk("tp4_q3", int'(Q[3*N +: N]), 103);
        chk("tp4_busy_cycles", nb, 5);

        // illegal config
        ch_sel = 0; cfg_we = 1; cfg_stride = 0; cfg_limit = 1023; tick();
        chk("tp5_err", int'(cfg_err), 1);
        idle_in(); ch_sel = 0; pim_load = 1; D = 7; tick();
        idle_in(); ch_sel = 0; update = 1; tick();
        chk("tp5_q0", int'(Q[0 +: N]), 8);
        idle_in(); tick(); tick();
        chk("tp5_err_sticky", int'(cfg_err), 1);

        // reset mid-burst
        ch_sel = 1; burst_start = 1; burst_len = 5; tick();
        idle_in(); tick(); tick();
        rst_n = 0; tick();
        chk("tp6_busy", int'(busy), 0);
        chk("tp6_done", int'(done), 0);
        chk("tp6_q1", int'(Q[1*N +: N]), 0);
        chk("tp6_err", int'(cfg_err), 0);
        idle_in(); tick();
        chk("tp6_idle", int'(busy), 0);

`ifdef SRC_ADDR_GEN_SAT_EN
        ch_sel = 0; cfg_we = 1; cfg_stride = 3; cfg_limit = 10; tick();
        idle_in(); ch_sel = 0; pim_load = 1; D = 9; tick();
        idle_in(); ch_sel = 0; update = 1; tick();
        chk("sat_q", int'(Q[0 +: N]), 10);
        chk("sat_wrap", int'(wrap[0]), 1);
        tick();
        chk("sat_q_hold", int'(Q[0 +: N]), 10);
        chk("sat_no_wrap", int'(wrap[0]), 0);
        idle_in();
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            rst_n       = ($urandom_range(0, 199) != 0);
            ch_sel      = CW'($urandom_range(0, NCH - 1));
            D           = N'($urandom_range(0, AMAX));
            mov_in      = N'($urandom_range(0, AMAX));
            pim_load    = ($urandom_range(0, 9) == 0);
            mov_load    = ($urandom_range(0, 9) == 0);
            update      = ($urandom_range(0, 9) < 4);
            cfg_we      = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       cfg_stride = '0;
                1:       cfg_stride = N'($urandom_range(0, AMAX));
                default: cfg_stride = N'($urandom_range(1, 8));
            endcase
            cfg_limit   = $urandom_range(0, 1) ? N'(AMAX) : N'($urandom_range(0, AMAX));
            burst_start = ($urandom_range(0, 9) == 0);
            burst_len   = LW'($urandom_range(0, 12));
            tick();
        end
        idle_in();
        tick(); tick();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/src_addr_gen.md
Name: src_addr_gen

Overview:
- Parametrised successor to the single source-address register.
- NCH independent address channels, each N bits wide.
- Each channel supports direct PIM load, MOV load, and stride update with modulo-limit wrap.
- A burst engine auto-steps one channel for a programmed count; feeds source-address buses of the PIM array controller.

Parameters:
- N, 10, address width per channel (≥2).
- NCH, 4, number of channels (≥1).
- CW, $clog2(NCH) (min 1), channel-select width.
- LW, 8, burst-length counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ch_sel  in  CW  channel addressed by pim_load/mov_load/update/cfg_we/burst_start.
- D  in  N  PIM load data.
- mov_in  in  N  MOV load data.
- pim_load  in  1  load D into Q[ch_sel].
- mov_load  in  1  load mov_in into Q[ch_sel].
- update  in  1  step Q[ch_sel] by its stride.
- cfg_we  in  1  write cfg_stride/cfg_limit for ch_sel.
- cfg_stride  in  N  step size.
- cfg_limit  in  N  highest legal address (inclusive).
- burst_start  in  1  start auto-stepping ch_sel.
- burst_len  in  LW  number of steps.
- Q  out  NCH*N  all channel addresses; channel i at [i*N +: N].
- q_sel  out  N  Q[ch_sel], combinational mux.
- wrap  out  NCH  per-channel one-cycle pulse on wrap.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- cfg_err  out  1  sticky illegal-config flag.

Behaviour:
- Reset (rst_n=0 at edge):
  - Q[i]=0; stride[i]=1; limit[i]=2^N-1.
  - FSM=IDLE; busy=0, done=0, wrap=0, cfg_err=0.
  - Reset wins over everything, including mid-burst.
- Per-channel priority each cycle: pim_load > mov_load > step > hold.
  - step = (update for ch_sel) OR (burst step for burst channel).
  - Q updates at the edge following the command; one-cycle latency.
- Step arithmetic:
  - s = Q + stride, computed in N+1 bits.
  - If s > limit: Q <= s - (limit+1) and pulse wrap[i]. Otherwise Q <= s[N-1:0].
  - Loads are never wrapped. A loaded value above limit is held as-is; the next step wraps it per the rule above.
- cfg_we:
  - If cfg_stride == 0 or cfg_stride > cfg_limit+1: store stride=1, store the given limit, set cfg_err.
  - Otherwise store both values.
  - Takes effect for steps from the next cycle.
  - cfg_err clears only on reset.
- Burst FSM states: IDLE, RUN, FIN.
  - IDLE + burst_start, burst_len>0: latch bch=ch_sel, cnt=burst_len; go RUN; busy=1 from the next cycle.
  - IDLE + burst_start, burst_len==0: go FIN, no step.
  - RUN: one step on bch per cycle, cnt--. When a step occurs with cnt==1, go FIN.
  - If pim_load or mov_load targets bch in RUN, the load wins. That cycle's step is skipped and cnt is not decremented (stall).
  - External update targeting bch during RUN is ignored. update to other channels proceeds normally.
  - FIN: done=1, busy=0, go IDLE.
  - burst_start in RUN or FIN is ignored.
- Simultaneous pim_load and mov_load: pim_load wins.

Optional Feature:
- SRC_ADDR_GEN_SAT_EN defined: a step with s > limit saturates to Q=limit. wrap[i] pulses only on the step that first reaches saturation from below limit.
- Undefined: modulo wrap as specified above.

Test Plan:
- Reset, then observe Q → all 0, busy=0. cfg ch1 stride=3 limit=10; pim_load ch1 D=8; update → Q1=0 (11-11), wrap[1] pulse one cycle.
- ch0: pim_load D=5 and mov_load mov_in=9 same cycle → Q0=5. Next cycle mov_load 9 + update → Q0=9.
- Burst ch2, stride=1, limit=1023, Q2=1020, burst_len=6 → Q2 sequence 1021,1022,1023,0,1,2; wrap[2] at 0; done one cycle after last step; busy high 6 cycles.
- Burst ch3 len=4; pim_load ch3 D=100 on 2nd RUN cycle → steps 1,(load),2,3,4; final Q3=103; busy high 5 cycles.
- cfg ch0 stride=0 → cfg_err=1, stride=1. Then update ch0 from Q0=7 → Q0=8. cfg_err stays 1 until rst_n=0.
- rst_n=0 mid-burst (ch1, cnt=3) → next cycle busy=0, done=0, Q1=0, FSM IDLE. With SRC_ADDR_GEN_SAT_EN: limit=10, Q=9, stride=3, update → Q=10, wrap pulse. Update again → Q=10, no wrap.
